dog_window_gen: RTL and testbench
=================================

// Module: dog_window_gen
// PURPOSE
//  Parametrised KxK sliding-window generator for the DoG feature stage. Accepts a raster-order
//  signed DoG pixel stream, buffers K-1 lines internally, and emits a full KxK neighbourhood
//  per accepted pixel, tagged with its centre coordinates. Border windows are suppressed.
//  Feeds extremum compare / keypoint logic downstream.
// PARAMETERS
//  WIDE    256  pixels per line
//  HIGN    256  lines per frame
//  DW      8    signed pixel width
//  K       3    window size; odd, 3..7
//  CNT_DW  16   coordinate counter width; must hold max(WIDE,HIGN)
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         reset, asynchronous, active-low
//  sof_in      in   1         start of frame; qualified by valid_in, marks pixel (0,0)
//  valid_in    in   1         data_in valid this cycle
//  data_in     in   DW        signed DoG pixel
//  win_valid   out  1         win_data/win_x/win_y valid; one-cycle pulse per window
//  win_data    out  K*K*DW    window; element (r,c) at [(r*K+c)*DW +: DW]
//  win_x       out  CNT_DW    centre column of window
//  win_y       out  CNT_DW    centre row of window
//  frame_done  out  1         one-cycle pulse after last pixel of frame accepted
// BEHAVIOUR
//  - Reset: every output 0; col/row counters 0; window registers 0. Line memory not cleared.
//  - Accept: a pixel is accepted when valid_in=1. Without valid_in nothing moves; stalls any length.
//  - Counters: col_in/row_in give the accepted pixel's position. Advance col on accept; at WIDE-1
//    wrap to 0 and advance row; at (WIDE-1,HIGN-1) wrap both to 0.
//    sof_in&valid_in forces the pixel to (0,0) regardless of counters; the partial frame is dropped.
//  - Line memory: K-1 circular line buffers, WIDE deep, indexed by col_in. Accept reads the K-1
//    older pixels at col_in (rows row_in-K+1..row_in-1), then writes data_in down the chain.
//    Read-before-write at the same address is required.
//  - Window: KxK register array. Each accept shifts every row left by one column and loads the
//    new column at c=K-1: r=K-1 gets data_in, r=0 gets the oldest line. r=0 is the top (oldest)
//    row; c=0 is the leftmost (oldest) column.
//  - Latency: win_* is registered 1 cycle after the accept that completes the window.
//  - Gating: win_valid=1 only if col_in>=K-1 and row_in>=K-1 for that accept.
//    Then win_x=col_in-(K-1)/2 and win_y=row_in-(K-1)/2. No padding is applied.
//    Windows spanning a line wrap, or reading previous-frame line data, are never flagged valid.
//  - Hold: win_data/win_x/win_y hold their last value when win_valid=0.
//  - frame_done: registered together with win_valid for the (WIDE-1,HIGN-1) accept.
//    It pulses even if that window is also the last valid window.
//  - Arithmetic: data is passed through unmodified, sign preserved. Counters are unsigned CNT_DW.
//  - Reset mid-frame clears counters and window; the next accept is treated as (0,0).
//  - Any sustained valid_in pattern, including every cycle, must be accepted without loss.
// TESTING
//  Test setup for T1-T4: WIDE=8, HIGN=6, K=3, data=(row*16+col) mod 128, valid_in every cycle.
//  T1: one full frame -> exactly 24 win_valid pulses. First pulse has (win_x,win_y)=(1,1) and
//      win_data rows {0,1,2},{16,17,18},{32,33,34}. Last pulse is at (6,4).
//  T2: T1 with valid_in randomly low 50% -> identical window sequence, each pulse 1 cycle after
//      its completing accept.
//  T3: two back-to-back frames, second with data negated -> no win_valid for rows 0-1 of frame 2.
//      Frame 2's first window is (1,1) with value -17 at r=1,c=1. frame_done pulses twice.
//  T4: sof_in asserted at pixel (3,2) of frame 1 -> counters restart. The next valid window is
//      (1,1) built only from post-sof data.
//  T5: K=5, WIDE=16, HIGN=10 -> 72 windows. First at (2,2) with element (4,4)=4*16+4=68.
//  T6: rst low for 1 cycle mid-frame -> all outputs 0 that cycle. Next accepted pixel is (0,0).
//      No spurious win_valid follows.

Source files
------------

// File: rtl/dog_window_gen.sv
// dog_window_gen: KxK sliding-window generator for the DoG feature stage.
// Takes a raster-order signed pixel stream, keeps K-1 previous lines in a
// circular line store and emits one registered KxK neighbourhood per accepted
// pixel whose window lies fully inside the current frame.
module dog_window_gen #(
  parameter int WIDE   = 256,
  parameter int HIGN   = 256,
  parameter int DW     = 8,
  parameter int K      = 3,
  parameter int CNT_DW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof_in,
  input  logic                  valid_in,
  input  logic [DW-1:0]         data_in,
  output logic                  win_valid,
  output logic [K*K*DW-1:0]     win_data,
  output logic [CNT_DW-1:0]     win_x,
  output logic [CNT_DW-1:0]     win_y,
  output logic                  frame_done
);

  localparam int AW   = (WIDE > 1) ? $clog2(WIDE) : 1;
  localparam int HALF = (K - 1) / 2;

  // Position bookkeeping: *_cnt is where the next pixel would land,
  // *_in is the effective position of the pixel on the bus this cycle.
  logic [CNT_DW-1:0] col_cnt, row_cnt;
  logic [CNT_DW-1:0] col_in, row_in;
  logic [CNT_DW-1:0] col_nxt, row_nxt;
  logic [AW-1:0]     addr;
  logic              at_last_col, at_last_row, full_win;

  // One word per column holds all K-1 older rows: word[0] is row-1,
  // word[K-2] is row-K+1. Writing {older taps, data_in} shifts the chain.
  logic [K-2:0][DW-1:0] line_mem [WIDE];
  logic [K-2:0][DW-1:0] tap;

  // Packed so that element (r,c) sits at [(r*K+c)*DW +: DW] of the flat view.
  logic [K-1:0][K-1:0][DW-1:0] win_q, win_d;

  // Effective pixel position: sof forces (0,0), otherwise the running counters.
  always_comb begin
    col_in = sof_in ? '0 : col_cnt;
    row_in = sof_in ? '0 : row_cnt;
    addr   = col_in[AW-1:0];
    at_last_col = (col_in == CNT_DW'(WIDE - 1));
    at_last_row = (row_in == CNT_DW'(HIGN - 1));
    full_win    = (col_in >= CNT_DW'(K - 1)) && (row_in >= CNT_DW'(K - 1));
  end

  // Raster advance with wrap at end of line and end of frame.
  always_comb begin
    col_nxt = col_in + CNT_DW'(1);
    row_nxt = row_in;
    if (at_last_col) begin
      col_nxt = '0;
      row_nxt = at_last_row ? '0 : row_in + CNT_DW'(1);
    end
  end

  // Asynchronous read of the older rows at the current column; the write below
  // lands at the clock edge, so the same-address read sees pre-write data.
  always_comb begin
    tap = line_mem[addr];
  end

  // Next window: shift every row left, load the new column at c=K-1 with the
  // oldest line on top and the incoming pixel at the bottom.
  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c + 1 < K; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int unsigned r = 0; r + 1 < K; r++) begin
      win_d[r][K-1] = tap[K-2-r];
    end
    win_d[K-1][K-1] = data_in;
  end

  // Line store update; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      if (K > 3) begin
        line_mem[addr] <= {tap[K-3:0], data_in};
      end else begin
        line_mem[addr] <= {tap[0], data_in};
      end
    end
  end

  // Position counters and window array advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      win_q   <= '0;
    end else if (valid_in) begin
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      win_q   <= win_d;
    end
  end

  // Registered outputs: strobes pulse for one cycle, payload holds between windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_data   <= '0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      win_valid  <= valid_in && full_win;
      frame_done <= valid_in && at_last_col && at_last_row;
      if (valid_in && full_win) begin
        win_data <= win_d;
        win_x    <= col_in - CNT_DW'(HALF);
        win_y    <= row_in - CNT_DW'(HALF);
      end
    end
  end

endmodule

// File: tb/tb_dog_window_gen.sv
// Directed bench for dog_window_gen: a 8x6 K=3 instance checked against an
// image-based reference every cycle, plus a 16x10 K=5 instance.
module tb_dog_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         sof_a, valid_a, wv_a, fd_a;
  logic [7:0]   data_a;
  logic [71:0]  wd_a;
  logic [15:0]  wx_a, wy_a;

  logic         sof_b, valid_b, wv_b, fd_b;
  logic [7:0]   data_b;
  logic [199:0] wd_b;
  logic [15:0]  wx_b, wy_b;

  dog_window_gen #(.WIDE(8), .HIGN(6), .DW(8), .K(3), .CNT_DW(16)) dut_a (
    .clk(clk), .rst(rst), .sof_in(sof_a), .valid_in(valid_a), .data_in(data_a),
    .win_valid(wv_a), .win_data(wd_a), .win_x(wx_a), .win_y(wy_a), .frame_done(fd_a)
  );

  dog_window_gen #(.WIDE(16), .HIGN(10), .DW(8), .K(5), .CNT_DW(16)) dut_b (
    .clk(clk), .rst(rst), .sof_in(sof_b), .valid_in(valid_b), .data_in(data_b),
    .win_valid(wv_b), .win_data(wd_b), .win_x(wx_b), .win_y(wy_b), .frame_done(fd_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state for instance a
  int          ex, ey;
  logic [7:0]  img [6][8];
  logic [71:0] last_d;
  logic [15:0] last_x, last_y;
  int          pulses_a, fdone_a;
  logic        cap_done;
  logic [71:0] cap_d;
  logic [15:0] cap_x, cap_y, lst_x, lst_y;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int y, input int x, input int mode);
    logic [7:0] v;
    v = 8'((y * 16 + x) % 128);
    if (mode == 1) v = 8'(0 - int'(v));
    if (mode == 2) v = 8'(100 + y * 16 + x);
    return v;
  endfunction

  // One cycle on instance a, with model update and full output check.
  task automatic step_a(input logic v, input logic s, input logic [7:0] d);
    logic ev, ef;
    @(negedge clk);
    valid_a = v; sof_a = s; data_a = d;
    ev = 1'b0; ef = 1'b0;
    if (v) begin
      if (s) begin ex = 0; ey = 0; end
      img[ey][ex] = d;
      ev = (ex >= 2) && (ey >= 2);
      ef = (ex == 7) && (ey == 5);
      if (ev) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            last_d[(r*3+c)*8 +: 8] = img[ey-2+r][ex-2+c];
        last_x = 16'(ex - 1);
        last_y = 16'(ey - 1);
      end
      ex++;
      if (ex == 8) begin
        ex = 0;
        ey = (ey == 5) ? 0 : ey + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("a_valid", 256'(wv_a), 256'(ev));
    chk("a_frame_done", 256'(fd_a), 256'(ef));
    chk("a_data", 256'(wd_a), 256'(last_d));
    chk("a_x", 256'(wx_a), 256'(last_x));
    chk("a_y", 256'(wy_a), 256'(last_y));
    if (wv_a) begin
      pulses_a++;
      if (!cap_done) begin
        cap_done = 1'b1; cap_d = wd_a; cap_x = wx_a; cap_y = wy_a;
      end
      lst_x = wx_a; lst_y = wy_a;
    end
    if (fd_a) fdone_a++;
  endtask

  task automatic frame_a(input int mode, input logic sof_first, input int stall);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        if (stall != 0 && $urandom_range(0, 1) == 0) step_a(1'b0, 1'b0, 8'h00);
        step_a(1'b1, sof_first && x == 0 && y == 0, pix(y, x, mode));
      end
  endtask

  task automatic clear_stats();
    pulses_a = 0; fdone_a = 0; cap_done = 1'b0;
  endtask

  int pulses_b, fdone_b;

  initial begin
    rst = 1'b0;
    sof_a = 1'b0; valid_a = 1'b0; data_a = '0;
    sof_b = 1'b0; valid_b = 1'b0; data_b = '0;
    ex = 0; ey = 0; last_d = '0; last_x = '0; last_y = '0;
    cap_d = '0; cap_x = '0; cap_y = '0; lst_x = '0; lst_y = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 256'(wv_a), 256'd0);
    chk("reset_data", 256'(wd_a), 256'd0);
    chk("reset_fd_b", 256'(fd_b), 256'd0);
    @(negedge clk);
    rst = 1'b1;

    // T1: one full frame, valid every cycle
    clear_stats();
    frame_a(0, 1'b0, 0);
    chk("t1_pulses", 256'(pulses_a), 256'd24);
    chk("t1_fdone", 256'(fdone_a), 256'd1);
    chk("t1_first_x", 256'(cap_x), 256'd1);
    chk("t1_first_y", 256'(cap_y), 256'd1);
    chk("t1_first_data", 256'(cap_d),
        256'({8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0}));
    chk("t1_last_x", 256'(lst_x), 256'd6);
    chk("t1_last_y", 256'(lst_y), 256'd4);

    // T2: same frame with random stalls
    clear_stats();
    frame_a(0, 1'b0, 1);
    chk("t2_pulses", 256'(pulses_a), 256'd24);
    chk("t2_fdone", 256'(fdone_a), 256'd1);

    // T3: back-to-back frames, second negated
    clear_stats();
    frame_a(0, 1'b1, 0);
    cap_done = 1'b0;
    frame_a(1, 1'b1, 0);
    chk("t3_pulses", 256'(pulses_a), 256'd48);
    chk("t3_fdone", 256'(fdone_a), 256'd2);
    chk("t3_f2_first_x", 256'(cap_x), 256'd1);
    chk("t3_f2_first_y", 256'(cap_y), 256'd1);
    chk("t3_f2_centre", 256'(cap_d[32 +: 8]), 256'h0ef);

    // T4: sof mid-frame at (3,2), then a fresh frame from that pixel
    for (int i = 0; i < 19; i++) step_a(1'b1, 1'b0, pix(i / 8, i % 8, 0));
    clear_stats();
    frame_a(2, 1'b1, 0);
    chk("t4_first_x", 256'(cap_x), 256'd1);
    chk("t4_first_y", 256'(cap_y), 256'd1);
    chk("t4_first_r0c0", 256'(cap_d[7:0]), 256'd100);
    chk("t4_first_r2c2", 256'(cap_d[64 +: 8]), 256'd134);
    chk("t4_pulses", 256'(pulses_a), 256'd24);

    // T5: K=5 on a 16x10 frame
    @(negedge clk);
    valid_a = 1'b0;
    pulses_b = 0; fdone_b = 0;
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 16; x++) begin
        @(negedge clk);
        valid_b = 1'b1; data_b = pix(y, x, 0);
        @(posedge clk);
        #1;
        chk("b_valid", 256'(wv_b), 256'((x >= 4) && (y >= 4)));
        chk("b_frame_done", 256'(fd_b), 256'((x == 15) && (y == 9)));
        if (wv_b) pulses_b++;
        if (fd_b) fdone_b++;
        if (x == 4 && y == 4) begin
          chk("b_first_x", 256'(wx_b), 256'd2);
          chk("b_first_y", 256'(wy_b), 256'd2);
          chk("b_first_e44", 256'(wd_b[24*8 +: 8]), 256'd68);
          chk("b_first_e00", 256'(wd_b[7:0]), 256'd0);
          chk("b_first_e21", 256'(wd_b[11*8 +: 8]), 256'd33);
        end
        if (x == 15 && y == 9) begin
          chk("b_last_x", 256'(wx_b), 256'd13);
          chk("b_last_y", 256'(wy_b), 256'd7);
        end
      end
    @(negedge clk);
    valid_b = 1'b0;
    chk("b_pulses", 256'(pulses_b), 256'd72);
    chk("b_fdone", 256'(fdone_b), 256'd1);

    // T6: one-cycle reset mid-frame
    for (int i = 0; i < 20; i++) step_a(1'b1, i == 0, pix(i / 8, i % 8, 0));
    @(negedge clk);
    valid_a = 1'b1; data_a = 8'h55;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 256'(wv_a), 256'd0);
    chk("t6_rst_fd", 256'(fd_a), 256'd0);
    chk("t6_rst_data", 256'(wd_a), 256'd0);
    chk("t6_rst_x", 256'(wx_a), 256'd0);
    chk("t6_rst_y", 256'(wy_a), 256'd0);
    @(negedge clk);
    valid_a = 1'b0;
    rst = 1'b1;
    ex = 0; ey = 0; last_d = '0; last_x = '0; last_y = '0;
    clear_stats();
    frame_a(2, 1'b0, 0);
    chk("t6_pulses", 256'(pulses_a), 256'd24);
    chk("t6_first_x", 256'(cap_x), 256'd1);
    chk("t6_first_y", 256'(cap_y), 256'd1);
    chk("t6_fdone", 256'(fdone_a), 256'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
